// File: rtl/run_step_controller.sv
// Run/step sequencer: debounces the dock buttons and produces a one-cycle
// register load enable, either on manual step (HALT) or periodically (RUN).
module run_step_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned RUN_DIV         = 6750000,
    parameter int unsigned COUNT_W         = 16
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               btn_run,
    input  logic               btn_step,
    input  logic               btn_halt,
    output logic               load,
    output logic               running,
    output logic               beat,
    output logic [COUNT_W-1:0] step_count
);

    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned DIV_W = $clog2(RUN_DIV);

    typedef enum logic {
        HALT = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [2:0] raw;
    logic [2:0] ev;
    logic       step_ev;
    logic       run_ev;
    logic       halt_ev;

    assign raw     = {btn_halt, btn_run, btn_step};
    assign step_ev = ev[0];
    assign run_ev  = ev[1];
    assign halt_ev = ev[2];

    // Event pulse is registered alongside the 0->1 flip of the debounced level.
    for (genvar g = 0; g < 3; g++) begin : g_btn
        logic            s0;
        logic            s1;
        logic            lvl;
        logic            ev_q;
        logic [DB_W-1:0] cnt;

        always_ff @(posedge Clock or negedge Reset_n) begin
            if (!Reset_n) begin
                s0   <= 1'b0;
                s1   <= 1'b0;
                lvl  <= 1'b0;
                ev_q <= 1'b0;
                cnt  <= '0;
            end else begin
                s0   <= raw[g];
                s1   <= s0;
                ev_q <= 1'b0;
                if (s1 != lvl) begin
                    if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        lvl  <= s1;
                        cnt  <= '0;
                        ev_q <= s1;
                    end else begin
                        cnt <= cnt + DB_W'(1);
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end

        assign ev[g] = ev_q;
    end

    state_t           state;
    state_t           state_nx;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nx;
    logic             load_nx;

    always_comb begin
        state_nx = state;
        div_nx   = div;
        load_nx  = 1'b0;
        case (state)
            HALT: begin
                div_nx = '0;
                if (halt_ev) begin
                    state_nx = HALT;
                end else if (run_ev) begin
                    state_nx = RUN;
                end else if (step_ev && !load) begin
                    load_nx = 1'b1;
                end
            end
            RUN: begin
                if (halt_ev) begin
                    state_nx = HALT;
                    div_nx   = '0;
                end else if (div == DIV_W'(RUN_DIV - 1)) begin
                    div_nx  = '0;
                    load_nx = 1'b1;
                end else begin
                    div_nx = div + DIV_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= HALT;
            div        <= '0;
            load       <= 1'b0;
            beat       <= 1'b0;
            step_count <= '0;
        end else begin
            state <= state_nx;
            div   <= div_nx;
            load  <= load_nx;
            if (load) begin
                step_count <= step_count + COUNT_W'(1);
                beat       <= ~beat;
            end
        end
    end

    assign running = (state == RUN);

endmodule

// File: tb/tb_run_step_controller.sv
// Scoreboard bench for run_step_controller: expected load pulses are queued by
// the stimulus and consumed by a monitor whenever load is observed high.
module tb_run_step_controller;

    logic       clk;
    logic       rst_n;
    logic       btn_run;
    logic       btn_step;
    logic       btn_halt;
    logic       load;
    logic       running;
    logic       beat;
    logic [3:0] step_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] cnt;
        logic       bt;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] exp_cnt  = '0;
    logic       exp_beat = 1'b0;
    logic       prev_load = 1'b0;

    run_step_controller #(
        .DEBOUNCE_CYCLES(4),
        .RUN_DIV        (5),
        .COUNT_W        (4)
    ) dut (
        .Clock     (clk),
        .Reset_n   (rst_n),
        .btn_run   (btn_run),
        .btn_step  (btn_step),
        .btn_halt  (btn_halt),
        .load      (load),
        .running   (running),
        .beat      (beat),
        .step_count(step_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic expect_load();
        sb.push_back('{cnt: exp_cnt, bt: exp_beat});
        exp_cnt  = exp_cnt + 4'd1;
        exp_beat = ~exp_beat;
    endtask

    task automatic wait_running(input logic val);
        int n = 0;
        while (running !== val && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_running", int'(running), int'(val));
    endtask

    task automatic step_press();
        expect_load();
        btn_step = 1'b1;
        repeat (10) @(negedge clk);
        btn_step = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    // Monitor: every load pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (load === 1'b1) begin
            exp_t e;
            checks++;
            if (prev_load) begin
                errors++;
                $display("FAIL load_consecutive: load high two cycles at %0t", $time);
            end
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_load: got load=1 expected none, step_count=%0d at %0t",
                         step_count, $time);
            end else begin
                e = sb.pop_front();
                if (step_count !== e.cnt || beat !== e.bt) begin
                    errors++;
                    $display("FAIL load_state: got step_count=%0d beat=%0b expected %0d/%0b at %0t",
                             step_count, beat, e.cnt, e.bt, $time);
                end
            end
        end
        prev_load = (load === 1'b1);
    end

    initial begin
        int bad;
        int ok;
        logic exp_l;

        // Reset held with all buttons asserted
        rst_n    = 1'b0;
        btn_run  = 1'b1;
        btn_step = 1'b1;
        btn_halt = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_load", int'(load), 0);
        check("rst_running", int'(running), 0);
        check("rst_beat", int'(beat), 0);
        check("rst_count", int'(step_count), 0);

        btn_run  = 1'b0;
        btn_step = 1'b0;
        btn_halt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (load !== 1'b0 || running !== 1'b0 || beat !== 1'b0 || step_count !== 4'd0) bad++;
        end
        check("idle_after_reset_bad_cycles", bad, 0);

        // Single step
        step_press();
        check("step1_count", int'(step_count), 1);
        check("step1_beat", int'(beat), 1);
        check("step1_drained", sb.size(), 0);

        // 15 further presses: 16 total wraps the 4-bit counter
        for (int i = 0; i < 15; i++) step_press();
        check("wrap_count", int'(step_count), 0);
        check("wrap_beat", int'(beat), 0);
        check("wrap_drained", sb.size(), 0);

        // Bounce: runs of 3 never qualify
        for (int i = 0; i < 10; i++) begin
            btn_step = 1'b1; @(negedge clk);
            btn_step = 1'b1; @(negedge clk);
            btn_step = 1'b1; @(negedge clk);
            btn_step = 1'b0; @(negedge clk);
        end
        repeat (12) @(negedge clk);
        check("bounce_count", int'(step_count), int'(exp_cnt));
        check("bounce_drained", sb.size(), 0);

        // Run and halt rising together in HALT: halt wins
        btn_run  = 1'b1;
        btn_halt = 1'b1;
        bad = 0;
        repeat (14) begin
            @(negedge clk);
            if (running !== 1'b0) bad++;
        end
        btn_run  = 1'b0;
        btn_halt = 1'b0;
        repeat (12) @(negedge clk);
        check("prio_run_halt_running_cycles", bad, 0);
        check("prio_drained", sb.size(), 0);

        // RUN: loads 5, 10, 15 cycles after running rises; halt lands on the due cycle
        btn_run = 1'b1;
        @(negedge clk);
        wait_running(1'b1);
        btn_run  = 1'b0;
        btn_step = 1'b1;
        expect_load();
        expect_load();
        expect_load();
        ok = 1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            exp_l = (k == 5 || k == 10 || k == 15);
            if (load !== exp_l) begin
                ok = 0;
                $display("FAIL run_load_timing: cycle %0d got load=%0b expected %0b", k, load, exp_l);
            end
            if (k == 6) btn_step = 1'b0;
            if (k == 13) btn_halt = 1'b1;
        end
        check("run_load_timing_ok", ok, 1);
        check("run_before_halt", int'(running), 1);
        @(negedge clk);
        check("halt_running", int'(running), 0);
        check("halt_no_load", int'(load), 0);
        btn_halt = 1'b0;
        repeat (15) @(negedge clk);
        check("run_count", int'(step_count), 3);
        check("run_beat", int'(beat), 1);
        check("run_drained", sb.size(), 0);

        // Async reset in the middle of a load pulse
        btn_run = 1'b1;
        @(negedge clk);
        wait_running(1'b1);
        btn_run = 1'b0;
        expect_load();
        repeat (5) @(negedge clk);
        check("pre_reset_load", int'(load), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_load", int'(load), 0);
        check("async_running", int'(running), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        exp_cnt  = '0;
        exp_beat = 1'b0;
        repeat (12) @(negedge clk);
        check("post_reset_count", int'(step_count), 0);
        check("post_reset_beat", int'(beat), 0);
        check("post_reset_running", int'(running), 0);
        check("final_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
